matrix_4x4_mac_stream: RTL and testbench
========================================

// Module: matrix_4x4_mac_stream
// PURPOSE
//  Consumes one buffered operand pair (A, B, each 4x4, column vectors) from matrix_4x4_buff.
//  Computes C = A*B in signed fixed point, one element per pass.
//  Streams the 16 result elements out serially over a valid/ready handshake.
//  Element order is column-major, which is the same order in which matrix_4x4_buff accepts its inputs.
// PARAMETERS
//  W        12    signed fixed-point width (Q2.10 at default)
//  FXP_MUL  1024  scale factor; FRAC = $clog2(FXP_MUL) fractional bits
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  valid_in   in   1      upstream operands valid
//  ready_out  out  1      block can accept operands
//  aC1..aC4   in   4xW    columns of A; aCk[i] = A[i][k]
//  bC1..bC4   in   4xW    columns of B; bCj[k] = B[k][j]
//  valid_out  out  1      c_out holds a valid result element
//  ready_in   in   1      downstream accepts c_out
//  c_out      out  W      result element C[row_out][col_out], signed, saturated
//  row_out    out  2      row index i of c_out
//  col_out    out  2      column index j of c_out
//  last_out   out  1      high with the 16th element (i=3, j=3)
//  ovf_out    out  1      sticky: some element of the current matrix saturated
// BEHAVIOUR
//  Reset (rst=1 at posedge), from any state, mid-stream included:
//   state=IDLE, ready_out=0, valid_out=0, c_out=0, row/col=0, last_out=0, ovf_out=0, idx=0.
//   Any partial result stream is abandoned; no further elements are output.
//  States:
//   IDLE: ready_out=1, valid_out=0.
//    If valid_in && ready_out: register all 8 columns locally, idx<=0, ovf_out<=0,
//    ready_out<=0, go CALC. The transfer is exactly one cycle.
//   CALC: c_out<=dot(idx); row_out<=idx[1:0]; col_out<=idx[3:2]; last_out<=(idx==15);
//    ovf_out|=sat; valid_out<=1; go OUT.
//   OUT: c_out, row_out, col_out and last_out are held stable while ready_in=0 (no timeout).
//    If ready_in: valid_out<=0.
//     If idx==15: ready_out<=1, go IDLE.
//     Else: idx<=idx+1, go CALC.
//  Element mapping: idx 0..15, i=idx[1:0], j=idx[3:2].
//   C[i][j] = sum_k aCk[i] * bCj[k], for k=1..4.
//  Arithmetic:
//   Each product is signed WxW -> 2W bits.
//   The 4-term sum is 2W+2 bits, exact.
//   Scaling is an arithmetic shift right by FRAC (truncation toward -inf).
//   Saturate to [-2^(W-1), 2^(W-1)-1]; sat=1 when clipped.
//  Timing:
//   Latency from the operand handshake to the first valid_out is 2 clk.
//   Minimum spacing between elements is 2 clk each (CALC+OUT), so 32 clk per matrix at best.
//  Handshakes:
//   valid_in is ignored outside IDLE.
//   Local operand registers are stable for the whole stream, so upstream may refill meanwhile.
//   valid_out never drops without ready_in (or rst).
//   ovf_out is valid from the first element until the next operand capture.
// STRUCTURE
//  Package matrix_pkg:
//   W / FRAC defaults.
//   typedef logic signed [W-1:0] fxp_t.
//   typedef fxp_t [3:0] vec4_t.
//   state enum {IDLE, CALC, OUT}.
//   Constants FXP_MAX and FXP_MIN.
//  Sub-module matrix_4x4_dot4: combinational.
//   Inputs: two vec4_t.
//   Outputs: saturated fxp_t and sat flag.
//   Contains the 4 multipliers, adder tree, shift and saturation.
//  This module: FSM, idx counter, operand registers, A-row/B-column mux into dot4, output registers.
// TESTING
//  1 A=identity (0x400 on the diagonal, 0 elsewhere), B[k][j]=0x100*(k+4j-7)
//    -> 16 outputs equal to B in column-major order.
//    -> last_out only on #16; ovf_out=0.
//  2 A=B=all 0x200 (0.5) -> every c_out=0x400 (1.0).
//    -> first valid_out exactly 2 clk after the operand handshake.
//  3 A=B=all 0x7FF -> every c_out=0x7FF and ovf_out=1.
//    A=all 0x7FF, B=all 0x800 -> every c_out=0x800 and ovf_out=1.
//  4 Hold ready_in=0 for 5 clk at element #3 -> c_out, row_out and col_out are unchanged.
//    -> no element is skipped or duplicated after release.
//    -> valid_in pulses during the stream are not accepted.
//  5 Assert rst for 1 clk while at element #7 -> next cycle all outputs equal their reset values.
//    -> the next operand pair streams correctly from idx=0.
//  6 Back-to-back matrices with ready_in=1 always -> 32 clk per matrix plus 1 IDLE clk.
//    -> ovf_out is cleared on the second capture.

Source files
------------

// File: rtl/matrix_4x4_mac_stream_pkg.sv
// Shared types and constants for the 4x4 fixed-point matrix multiply stream.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default width/scale, fxp_t, vec4_t, FSM state enum, FXP_MAX/FXP_MIN.
package matrix_pkg;

  localparam int W       = 12;
  localparam int FXP_MUL = 1024;
  localparam int FRAC    = $clog2(FXP_MUL);

  typedef logic signed [W-1:0] fxp_t;
  typedef fxp_t [3:0]          vec4_t;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  localparam fxp_t FXP_MAX = {1'b0, {(W-1){1'b1}}};
  localparam fxp_t FXP_MIN = {1'b1, {(W-1){1'b0}}};

endpackage

// File: rtl/matrix_4x4_mac_stream_if.sv
// Operand-in / result-out handshake bundle for matrix_4x4_mac_stream.
// Latency: n/a (wires only).
// Backpressure: valid_in/ready_out upstream, valid_out/ready_in downstream.
// slave = the multiplier block, master = the surrounding logic (or bench).
// aCk[i] = A[i][k], bCj[k] = B[k][j]; c_out carries a signed value as raw bits.
interface matrix_4x4_mac_stream_if #(
  parameter int W = matrix_pkg::W
);
  logic              valid_in;
  logic              ready_out;
  logic [3:0][W-1:0] aC1, aC2, aC3, aC4;
  logic [3:0][W-1:0] bC1, bC2, bC3, bC4;
  logic              valid_out;
  logic              ready_in;
  logic [W-1:0]      c_out;
  logic [1:0]        row_out;
  logic [1:0]        col_out;
  logic              last_out;
  logic              ovf_out;

  modport slave (
    input  valid_in, aC1, aC2, aC3, aC4, bC1, bC2, bC3, bC4, ready_in,
    output ready_out, valid_out, c_out, row_out, col_out, last_out, ovf_out
  );

  modport master (
    output valid_in, aC1, aC2, aC3, aC4, bC1, bC2, bC3, bC4, ready_in,
    input  ready_out, valid_out, c_out, row_out, col_out, last_out, ovf_out
  );
endinterface

// File: rtl/matrix_4x4_dot4.sv
// Signed 4-term dot product, scaled by 2^-FRAC and saturated to W bits.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (4 x W signed) in; y (W, saturated) and sat (clip flag) out.
module matrix_4x4_dot4 #(
  parameter int W    = matrix_pkg::W,
  parameter int FRAC = matrix_pkg::FRAC
) (
  input  logic [3:0][W-1:0] a,
  input  logic [3:0][W-1:0] b,
  output logic [W-1:0]      y,
  output logic              sat
);
  localparam int SW = 2*W + 2;
  localparam logic signed [SW-1:0] MAX_S = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_S = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic [2*W-1:0]        prod [4];
  logic signed [SW-1:0]  sum;
  logic signed [SW-1:0]  scaled;

  always_comb begin
    sum = '0;
    for (int k = 0; k < 4; k++) begin
      // Sign-extend both operands to 2W: the low 2W bits of the unsigned
      // product are then the exact two's-complement signed product.
      prod[k] = {{W{a[k][W-1]}}, a[k]} * {{W{b[k][W-1]}}, b[k]};
      sum     = sum + {{2{prod[k][2*W-1]}}, prod[k]};
    end
    // Arithmetic shift: truncation toward minus infinity.
    scaled = sum >>> FRAC;
    y      = scaled[W-1:0];
    sat    = 1'b0;
    if (scaled > MAX_S) begin
      y   = MAX_S[W-1:0];
      sat = 1'b1;
    end else if (scaled < MIN_S) begin
      y   = MIN_S[W-1:0];
      sat = 1'b1;
    end
  end
endmodule

// File: rtl/matrix_4x4_mac_stream.sv
// Captures one 4x4 operand pair and streams C = A*B out element by element, column-major.
// Latency: 2 clk from operand handshake to first valid_out; 2 clk per element minimum.
// Backpressure: result held stable while ready_in=0; operands refused outside IDLE.
// Ports: clk, rst (sync, active high); io (slave modport): operand and result handshakes.
module matrix_4x4_mac_stream
  import matrix_pkg::*;
#(
  parameter int W       = matrix_pkg::W,
  parameter int FXP_MUL = matrix_pkg::FXP_MUL
) (
  input logic                     clk,
  input logic                     rst,
  matrix_4x4_mac_stream_if.slave  io
);
  localparam int FRAC = $clog2(FXP_MUL);

  state_t                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  // a_q[k][i] = A[i][k]  (column k of A);  b_q[j][k] = B[k][j]  (column j of B)
  logic [3:0][3:0][W-1:0]  a_q, b_q;
  logic [3:0][W-1:0]       a_row, b_col;
  logic [W-1:0]            dot_y;
  logic                    dot_sat;
  logic                    load;

  logic [W-1:0] c_q, c_d;
  logic [1:0]   row_q, row_d, col_q, col_d;
  logic         last_q, last_d, ovf_q, ovf_d, vld_q, vld_d, rdy_q, rdy_d;

  assign load = (state_q == IDLE) && io.valid_in && rdy_q;

  // Operands are only written on capture, so upstream may present the next
  // pair while the current one is still streaming.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q <= {io.aC4, io.aC3, io.aC2, io.aC1};
      b_q <= {io.bC4, io.bC3, io.bC2, io.bC1};
    end
  end

  // Row i of A and column j of B for element idx (i = idx[1:0], j = idx[3:2]).
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      a_row[k] = a_q[k][idx_q[1:0]];
    end
    b_col = b_q[idx_q[3:2]];
  end

  matrix_4x4_dot4 #(.W(W), .FRAC(FRAC)) u_dot4 (
    .a   (a_row),
    .b   (b_col),
    .y   (dot_y),
    .sat (dot_sat)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c_d     = c_q;
    row_d   = row_q;
    col_d   = col_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    rdy_d   = rdy_q;
    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        vld_d = 1'b0;
        if (load) begin
          idx_d   = '0;
          ovf_d   = 1'b0;
          rdy_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        c_d     = dot_y;
        row_d   = idx_q[1:0];
        col_d   = idx_q[3:2];
        last_d  = (idx_q == 4'd15);
        ovf_d   = ovf_q | dot_sat;
        vld_d   = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (io.ready_in) begin
          vld_d = 1'b0;
          if (idx_q == 4'd15) begin
            rdy_d   = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = CALC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      c_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      row_q   <= row_d;
      col_q   <= col_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
    end
  end

  assign io.ready_out = rdy_q;
  assign io.valid_out = vld_q;
  assign io.c_out     = c_q;
  assign io.row_out   = row_q;
  assign io.col_out   = col_q;
  assign io.last_out  = last_q;
  assign io.ovf_out   = ovf_q;
endmodule

// File: tb/tb_matrix_4x4_mac_stream.sv
// Directed bench for matrix_4x4_mac_stream: hand-computed result matrices,
// backpressure hold, mid-stream reset and back-to-back throughput.
module tb_matrix_4x4_mac_stream;
  import matrix_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   first_cyc = 0;

  matrix_4x4_mac_stream_if #(.W(12)) io ();

  matrix_4x4_mac_stream dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [11:0] ma [4][4];  // ma[i][k] = A[i][k]
  logic [11:0] mb [4][4];  // mb[k][j] = B[k][j]
  logic [11:0] exp_c [16]; // expected c_out, column-major

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic fill_ab(input logic [11:0] av, input logic [11:0] bv);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = av;
        mb[i][k] = bv;
      end
  endtask

  task automatic set_identity_ramp();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = (i == k) ? 12'h400 : 12'h000;
        mb[i][k] = 12'(256 * (i + 4*k - 7));
      end
  endtask

  task automatic fill_exp(input logic [11:0] v);
    for (int e = 0; e < 16; e++) exp_c[e] = v;
  endtask

  task automatic exp_from_b();
    for (int e = 0; e < 16; e++) exp_c[e] = mb[e % 4][e / 4];
  endtask

  task automatic load_ops();
    for (int i = 0; i < 4; i++) begin
      io.aC1[i] = ma[i][0]; io.aC2[i] = ma[i][1];
      io.aC3[i] = ma[i][2]; io.aC4[i] = ma[i][3];
      io.bC1[i] = mb[i][0]; io.bC2[i] = mb[i][1];
      io.bC3[i] = mb[i][2]; io.bC4[i] = mb[i][3];
    end
  endtask

  task automatic zero_ops();
    io.aC1 = '0; io.aC2 = '0; io.aC3 = '0; io.aC4 = '0;
    io.bC1 = '0; io.bC2 = '0; io.bC3 = '0; io.bC4 = '0;
  endtask

  // Operand handshake; returns #1 after the capturing edge.
  task automatic send(input bit keep_valid);
    int n;
    n = 0;
    while (!io.ready_out && n < 20) begin tick(); n++; end
    chk("ready_out_wait", 32'(io.ready_out), 32'd1);
    io.valid_in = 1'b1;
    tick();
    if (!keep_valid) io.valid_in = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready_out"}, 32'(io.ready_out), 32'd0);
    chk({tag, "_valid_out"}, 32'(io.valid_out), 32'd0);
    chk({tag, "_c_out"},     32'(io.c_out),     32'd0);
    chk({tag, "_row_out"},   32'(io.row_out),   32'd0);
    chk({tag, "_col_out"},   32'(io.col_out),   32'd0);
    chk({tag, "_last_out"},  32'(io.last_out),  32'd0);
    chk({tag, "_ovf_out"},   32'(io.ovf_out),   32'd0);
  endtask

  // Receives elements against exp_c. hold_at: element held 5 clk with
  // ready_in=0 while zeroed operands are offered; stop_at: return while that
  // element is still presented.
  task automatic stream(input string tag, input int hold_at, input int stop_at, input bit exp_ovf);
    for (int e = 0; e < 16; e++) begin
      int n;
      n = 0;
      while (!io.valid_out && n < 10) begin tick(); n++; end
      if (e == 0) first_cyc = cyc;
      chk({tag, "_valid"}, 32'(io.valid_out), 32'd1);
      chk({tag, "_c"},     32'(io.c_out),     32'(exp_c[e]));
      chk({tag, "_row"},   32'(io.row_out),   32'(e % 4));
      chk({tag, "_col"},   32'(io.col_out),   32'(e / 4));
      chk({tag, "_last"},  32'(io.last_out),  32'(e == 15));
      chk({tag, "_ovf"},   32'(io.ovf_out),   32'(exp_ovf));
      if (e == stop_at) return;
      if (e == hold_at) begin
        io.ready_in = 1'b0;
        zero_ops();
        for (int h = 0; h < 5; h++) begin
          io.valid_in = h[0];
          tick();
          chk({tag, "_hold_valid"}, 32'(io.valid_out), 32'd1);
          chk({tag, "_hold_c"},     32'(io.c_out),     32'(exp_c[e]));
          chk({tag, "_hold_row"},   32'(io.row_out),   32'(e % 4));
          chk({tag, "_hold_col"},   32'(io.col_out),   32'(e / 4));
          chk({tag, "_hold_rdy"},   32'(io.ready_out), 32'd0);
        end
        io.valid_in = 1'b0;
        io.ready_in = 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    int c1;
    io.valid_in = 1'b0;
    io.ready_in = 1'b1;
    zero_ops();

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(io.ready_out), 32'd1);

    // 1: identity * ramp -> B back, column-major
    set_identity_ramp(); load_ops(); exp_from_b();
    send(1'b0);
    stream("ident", -1, -1, 1'b0);

    // A[0][0]=1 lsb, A[0][1]=1.0: row 0 = B[1][j] + floor(B[0][j]/1024), rest 0
    set_identity_ramp();
    fill_exp(12'h000);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) ma[i][k] = 12'h000;
    ma[0][0] = 12'h001;
    ma[0][1] = 12'h400;
    exp_c[0] = 12'h9FE; exp_c[4] = 12'hDFF; exp_c[8] = 12'h200; exp_c[12] = 12'h601;
    load_ops();
    send(1'b0);
    stream("asym", -1, -1, 1'b0);

    // 2: 0.5 everywhere -> 1.0, with exact first-element latency
    fill_ab(12'h200, 12'h200); load_ops(); fill_exp(12'h400);
    send(1'b0);
    chk("lat_1clk_valid", 32'(io.valid_out), 32'd0);
    tick();
    chk("lat_2clk_valid", 32'(io.valid_out), 32'd1);
    stream("half", -1, -1, 1'b0);

    // 3: positive and negative saturation
    fill_ab(12'h7FF, 12'h7FF); load_ops(); fill_exp(12'h7FF);
    send(1'b0);
    stream("satpos", -1, -1, 1'b1);
    fill_ab(12'h7FF, 12'h800); load_ops(); fill_exp(12'h800);
    send(1'b0);
    stream("satneg", -1, -1, 1'b1);

    // 4: backpressure on element #3 with stray valid_in pulses
    set_identity_ramp(); load_ops(); exp_from_b();
    send(1'b0);
    stream("hold", 2, -1, 1'b0);
    chk("hold_end_ready", 32'(io.ready_out), 32'd1);
    chk("hold_end_valid", 32'(io.valid_out), 32'd0);

    // 5: reset while presenting element #7, then a clean stream
    fill_ab(12'h7FF, 12'h7FF); load_ops(); fill_exp(12'h7FF);
    send(1'b0);
    stream("prerst", -1, 6, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("midrst");
    set_identity_ramp(); load_ops(); exp_from_b();
    send(1'b0);
    stream("postrst", -1, -1, 1'b0);

    // 6: back-to-back, second capture clears ovf_out
    fill_ab(12'h7FF, 12'h7FF); load_ops(); fill_exp(12'h7FF);
    send(1'b1);
    fill_ab(12'h200, 12'h200); load_ops();
    stream("b2b_first", -1, -1, 1'b1);
    c1 = first_cyc;
    fill_exp(12'h400);
    stream("b2b_second", -1, -1, 1'b0);
    io.valid_in = 1'b0;
    chk("b2b_spacing", 32'(first_cyc - c1), 32'd33);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
